// File: rtl/spad_pkg.sv
// Shared definitions for the SPAD readout path: sequencer state encoding,
// frame geometry and the layout of the 16-bit readout FIFO word.
package spad_pkg;

    localparam int unsigned SPAD_FRAME_PIX = 512;
    localparam int unsigned SPAD_ADDR_W    = 10;

    // FIFO word field offsets: {addr[9:0], pad, data[4:0]}
    localparam int unsigned ADDR_LSB = 6;
    localparam int unsigned PAD_BIT  = 5;
    localparam int unsigned DATA_W   = 5;
    localparam int unsigned WORD_W   = SPAD_ADDR_W + 1 + DATA_W;

    typedef struct packed {
        logic [SPAD_ADDR_W-1:0] addr;
        logic                   pad;
        logic [DATA_W-1:0]      data;
    } spad_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_PAUSE,
        ST_STOP,
        ST_DONE,
        ST_FLUSH
    } seq_state_t;

endpackage

// File: rtl/spad_frame_tracker.sv
// Snoops the readout FSM's FIFO writes: tracks the expected pixel address,
// flags order errors, strobes the FRAME_PIX-2 / frame-end writes and runs
// the inactivity watchdog.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   i_clr           clear expected address (acquisition start)
//   i_snoop         snooped writes are checked/counted only while high
//   i_wd_en         watchdog counting enable (counter held at 0 when low)
//   i_wd_kick       restart the watchdog (write seen or lock acquired)
//   i_fifowr/i_dout snooped FIFO write strobe and word
//   o_*_c           single-cycle combinational strobes for the sequencer
module spad_frame_tracker
    import spad_pkg::*;
#(
    parameter int unsigned FRAME_PIX   = SPAD_FRAME_PIX,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_snoop,
    input  logic              i_wd_en,
    input  logic              i_wd_kick,
    input  logic              i_fifowr,
    input  logic [WORD_W-1:0] i_dout,
    output logic              o_wr_bad_c,
    output logic              o_pre_end_c,
    output logic              o_frame_end_c,
    output logic              o_timeout_c
);

    localparam int unsigned PIX_W = $clog2(FRAME_PIX);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC) + 1;

    logic [PIX_W-1:0] r_exp_addr;
    logic [WD_W-1:0]  r_wd_cnt;
    spad_word_t       w_word;
    logic             w_snoop_wr;
    logic             w_match;
    logic             w_wr_ok;
    logic             w_unused_data;

    assign w_word        = i_dout;
    assign w_unused_data = ^w_word.data;
    assign w_snoop_wr    = i_snoop & i_fifowr;
    // Address field must equal the zero-extended expected address, pad bit clear
    assign w_match       = (w_word.addr == SPAD_ADDR_W'(r_exp_addr)) & ~w_word.pad;
    assign w_wr_ok       = w_snoop_wr & w_match;

    assign o_wr_bad_c    = w_snoop_wr & ~w_match;
    assign o_pre_end_c   = w_wr_ok & (r_exp_addr == PIX_W'(FRAME_PIX - 2));
    assign o_frame_end_c = w_wr_ok & (r_exp_addr == PIX_W'(FRAME_PIX - 1));
    assign o_timeout_c   = i_wd_en & ~i_wd_kick & (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Expected pixel address, wrapping at the end of each frame
    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_exp_addr <= '0;
        end else if (w_wr_ok) begin
            r_exp_addr <= (r_exp_addr == PIX_W'(FRAME_PIX - 1)) ? '0 : r_exp_addr + PIX_W'(1);
        end
    end

    // Watchdog: cycles since last kick while enabled
    always_ff @(posedge clk) begin
        if (!rst || !i_wd_en || i_wd_kick) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != WD_W'(TIMEOUT_CYC - 1)) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

endmodule

// File: rtl/spad_acq_sequencer.sv
// Frame-level acquisition controller for the SPAD readout FSM. Runs N frames
// or continuously, stops/pauses the FSM cleanly at frame boundaries, and
// flushes it on abort, address-order error or timeout.
// Ports:
//   clk, rst                      80 MHz clock, synchronous active-low reset
//   start, abort                  host one-cycle pulses
//   continuous, num_frames,
//   window_cfg                    run configuration, sampled at start
//   pll_locked, fifo_prog_full    status inputs
//   fsm_fifowr, fsm_dout          snooped readout-FSM FIFO writes
//   fsm_en, fsm_window_cycles,
//   fsm_rst                       controls to the readout FSM
//   busy, done, frames_done,
//   err_timeout, err_seq          status back to the host
module spad_acq_sequencer
    import spad_pkg::*;
#(
    parameter int unsigned FRAME_PIX   = SPAD_FRAME_PIX,
    parameter int unsigned FCNT_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned RST_CYC     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              continuous,
    input  logic [FCNT_W-1:0] num_frames,
    input  logic [1:0]        window_cfg,
    input  logic              pll_locked,
    input  logic              fifo_prog_full,
    input  logic              fsm_fifowr,
    input  logic [WORD_W-1:0] fsm_dout,
    output logic              fsm_en,
    output logic [1:0]        fsm_window_cycles,
    output logic              fsm_rst,
    output logic              busy,
    output logic              done,
    output logic [FCNT_W-1:0] frames_done,
    output logic              err_timeout,
    output logic              err_seq
);

    localparam int unsigned RST_W = $clog2(RST_CYC) + 1;

    seq_state_t        r_state;
    logic              r_cont;
    logic [FCNT_W-1:0] r_num;
    logic              r_frame_seen;
    logic [RST_W-1:0]  r_rst_cnt;
    logic              r_fsm_en;
    logic [1:0]        r_fsm_win;
    logic              r_fsm_rst;
    logic              r_busy;
    logic              r_done;
    logic [FCNT_W-1:0] r_frames_done;
    logic              r_err_timeout;
    logic              r_err_seq;

    logic w_snoop;
    logic w_armed;
    logic w_wd_en;
    logic w_wd_kick;
    logic w_clr;
    logic w_wr_bad;
    logic w_pre_end;
    logic w_frame_end;
    logic w_timeout;
    logic w_last;
    logic w_flush;

    assign w_snoop   = (r_state == ST_RUN) | (r_state == ST_PAUSE) | (r_state == ST_STOP);
    assign w_armed   = w_snoop | (r_state == ST_ARM);
    assign w_wd_en   = (r_state == ST_ARM) | (r_state == ST_RUN) | (r_state == ST_STOP);
    // Lock arriving ends the ARM wait, so it also restarts the watchdog for RUN
    assign w_wd_kick = fsm_fifowr | ((r_state == ST_ARM) & pll_locked);
    assign w_clr     = (r_state == ST_IDLE) & start;
    // frames_done has not yet counted the frame whose FRAME_PIX-2 write is in flight
    assign w_last    = ~r_cont & ((r_frames_done + FCNT_W'(1)) == r_num);
    assign w_flush   = w_armed & (abort | w_wr_bad | w_timeout);

    spad_frame_tracker #(
        .FRAME_PIX   (FRAME_PIX),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tracker (
        .clk           (clk),
        .rst           (rst),
        .i_clr         (w_clr),
        .i_snoop       (w_snoop),
        .i_wd_en       (w_wd_en),
        .i_wd_kick     (w_wd_kick),
        .i_fifowr      (fsm_fifowr),
        .i_dout        (fsm_dout),
        .o_wr_bad_c    (w_wr_bad),
        .o_pre_end_c   (w_pre_end),
        .o_frame_end_c (w_frame_end),
        .o_timeout_c   (w_timeout)
    );

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_cont        <= 1'b0;
            r_num         <= '0;
            r_frame_seen  <= 1'b0;
            r_rst_cnt     <= '0;
            r_fsm_en      <= 1'b0;
            r_fsm_win     <= '0;
            r_fsm_rst     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_frames_done <= '0;
            r_err_timeout <= 1'b0;
            r_err_seq     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A frame-end write counts even when an abort lands on the same cycle
            if (w_frame_end && !(&r_frames_done)) begin
                r_frames_done <= r_frames_done + FCNT_W'(1);
            end
            if (w_flush) begin
                r_state   <= ST_FLUSH;
                r_fsm_en  <= 1'b0;
                r_fsm_rst <= 1'b1;
                r_rst_cnt <= '0;
                if (!abort && w_wr_bad)  r_err_seq     <= 1'b1;
                if (!abort && w_timeout) r_err_timeout <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_cont        <= continuous;
                            r_num         <= num_frames;
                            r_fsm_win     <= window_cfg;
                            r_frames_done <= '0;
                            r_err_timeout <= 1'b0;
                            r_err_seq     <= 1'b0;
                            r_busy        <= 1'b1;
                            r_state       <= (!continuous && num_frames == '0) ? ST_DONE : ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        if (pll_locked) begin
                            r_fsm_en <= 1'b1;
                            r_state  <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        // Decide at FRAME_PIX-2 so en is low before the FSM's CLEAR sample
                        if (w_pre_end) begin
                            if (w_last) begin
                                r_fsm_en <= 1'b0;
                                r_state  <= ST_STOP;
                            end else if (fifo_prog_full) begin
                                r_fsm_en     <= 1'b0;
                                r_frame_seen <= 1'b0;
                                r_state      <= ST_PAUSE;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (w_frame_end) begin
                            r_frame_seen <= 1'b1;
                        end else if (r_frame_seen && !fifo_prog_full) begin
                            r_fsm_en <= 1'b1;
                            r_state  <= ST_RUN;
                        end
                    end
                    ST_STOP: begin
                        if (w_frame_end) r_state <= ST_DONE;
                    end
                    ST_DONE: begin
                        r_done   <= 1'b1;
                        r_fsm_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                    ST_FLUSH: begin
                        if (r_rst_cnt == RST_W'(RST_CYC - 1)) begin
                            r_fsm_rst <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + RST_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign fsm_en            = r_fsm_en;
    assign fsm_window_cycles = r_fsm_win;
    assign fsm_rst           = r_fsm_rst;
    assign busy              = r_busy;
    assign done              = r_done;
    assign frames_done       = r_frames_done;
    assign err_timeout       = r_err_timeout;
    assign err_seq           = r_err_seq;

endmodule

// File: tb/tb_spad_acq_sequencer.sv
// Bench for spad_acq_sequencer with a behavioural readout-FSM model that
// emits frames of in-order pixel writes with random gaps while enabled.
module tb_spad_acq_sequencer;

    localparam int FCNT_W  = 16;
    localparam int PIX     = 512;
    localparam int TIMEOUT = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              continuous = 1'b0;
    logic [FCNT_W-1:0] num_frames = '0;
    logic [1:0]        window_cfg = '0;
    logic              pll_locked = 1'b0;
    logic              fifo_prog_full = 1'b0;
    logic              fsm_fifowr = 1'b0;
    logic [15:0]       fsm_dout = '0;
    logic              fsm_en;
    logic [1:0]        fsm_window_cycles;
    logic              fsm_rst;
    logic              busy;
    logic              done;
    logic [FCNT_W-1:0] frames_done;
    logic              err_timeout;
    logic              err_seq;

    int n_cmp = 0;
    int n_err = 0;

    // Observation counters, cleared per scenario
    int n_wr, n_done, n_rst, n_en;
    bit wr_seen;
    int wr_addr;

    // Readout-FSM model: 0 idle, 1 emitting a frame, 2 end-of-frame enable sample
    int m_st = 0;
    int m_addr = 0;
    int m_frame = 0;
    bit m_stall = 1'b0;
    int inj_frame = 0;

    spad_acq_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .continuous        (continuous),
        .num_frames        (num_frames),
        .window_cfg        (window_cfg),
        .pll_locked        (pll_locked),
        .fifo_prog_full    (fifo_prog_full),
        .fsm_fifowr        (fsm_fifowr),
        .fsm_dout          (fsm_dout),
        .fsm_en            (fsm_en),
        .fsm_window_cycles (fsm_window_cycles),
        .fsm_rst           (fsm_rst),
        .busy              (busy),
        .done              (done),
        .frames_done       (frames_done),
        .err_timeout       (err_timeout),
        .err_seq           (err_seq)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        fsm_fifowr = 1'b0;
        fsm_dout   = '0;
        if (!rst || fsm_rst) begin
            m_st = 0;
            return;
        end
        case (m_st)
            0: if (fsm_en) begin m_st = 1; m_addr = 0; m_frame++; end
            1: if (!m_stall && $urandom_range(0, 3) != 0) begin
                   if (inj_frame == m_frame && m_addr == 6) m_addr = 7;
                   fsm_fifowr = 1'b1;
                   fsm_dout   = {10'(m_addr), 1'b0, 5'($urandom_range(0, 31))};
                   if (m_addr == PIX - 1) m_st = 2;
                   m_addr++;
               end
            default: if (fsm_en) begin m_st = 1; m_addr = 0; m_frame++; end
                     else m_st = 0;
        endcase
    endtask

    // One clock: observe what the DUT did at this edge, then drive the model
    task automatic tick();
        @(posedge clk);
        #1;
        wr_seen = fsm_fifowr;
        wr_addr = int'(fsm_dout[15:6]);
        if (wr_seen) n_wr++;
        if (done)    n_done++;
        if (fsm_rst) n_rst++;
        if (fsm_en)  n_en++;
        model_step();
    endtask

    task automatic clear_counts();
        n_wr = 0; n_done = 0; n_rst = 0; n_en = 0;
        m_frame = 0; m_st = 0; m_stall = 1'b0; inj_frame = 0;
        abort = 1'b0; fifo_prog_full = 1'b0; pll_locked = 1'b1;
    endtask

    task automatic do_start(input bit cont, input int nf, input int wc);
        continuous = cont;
        num_frames = FCNT_W'(nf);
        window_cfg = 2'(wc);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({fsm_en, fsm_window_cycles, fsm_rst, busy, done, frames_done, err_timeout, err_seq} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%b win=%0d rst=%b busy=%b done=%b frames=%0d et=%b es=%b, want all 0",
                     fsm_en, fsm_window_cycles, fsm_rst, busy, done, frames_done, err_timeout, err_seq);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_frame_count(input int nf, input int wc);
        int  b;
        logic exp_en;
        clear_counts();
        do_start(1'b0, nf, wc);
        n_cmp++;
        if (busy !== 1'b1 || fsm_window_cycles !== 2'(wc)) begin
            n_err++;
            $display("FAIL fc_start: busy=%b win=%0d, want busy=1 win=%0d", busy, fsm_window_cycles, wc);
        end
        b = 0;
        while (!done && b < 1000 * nf + 200) begin
            tick();
            b++;
            if (wr_seen && wr_addr == PIX - 2) begin
                exp_en = (n_wr != nf * PIX - 1);
                n_cmp++;
                if (fsm_en !== exp_en) begin
                    n_err++;
                    $display("FAIL fc_en_at_510: write %0d got en=%b want %b", n_wr, fsm_en, exp_en);
                end
            end
        end
        n_cmp++;
        if (done !== 1'b1 || frames_done !== FCNT_W'(nf) || busy !== 1'b0) begin
            n_err++;
            $display("FAIL fc_done: done=%b frames=%0d busy=%b, want done=1 frames=%0d busy=0", done, frames_done, busy, nf);
        end
        n_cmp++;
        if (n_wr != nf * PIX || err_seq !== 1'b0 || err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL fc_writes: writes=%0d es=%b et=%b, want writes=%0d no errors", n_wr, err_seq, err_timeout, nf * PIX);
        end
        repeat (5) tick();
        n_cmp++;
        if (n_done != 1 || fsm_en !== 1'b0 || frames_done !== FCNT_W'(nf)) begin
            n_err++;
            $display("FAIL fc_after: done_pulses=%0d en=%b frames=%0d, want 1/0/%0d", n_done, fsm_en, frames_done, nf);
        end
    endtask

    task automatic test_backpressure();
        int b;
        clear_counts();
        do_start(1'b0, 3, 2);
        b = 0;
        while (n_wr < 300 && b < 1000) begin tick(); b++; end
        fifo_prog_full = 1'b1;
        repeat (500 + $urandom_range(0, 200)) tick();
        n_cmp++;
        if (fsm_en !== 1'b0 || frames_done !== FCNT_W'(1) || n_wr != PIX || busy !== 1'b1) begin
            n_err++;
            $display("FAIL bp_paused: en=%b frames=%0d writes=%0d busy=%b, want 0/1/%0d/1", fsm_en, frames_done, n_wr, busy, PIX);
        end
        fifo_prog_full = 1'b0;
        tick();
        n_cmp++;
        if (fsm_en !== 1'b1) begin
            n_err++;
            $display("FAIL bp_resume: en=%b want 1", fsm_en);
        end
        b = 0;
        while (!done && b < 3000) begin tick(); b++; end
        n_cmp++;
        if (done !== 1'b1 || frames_done !== FCNT_W'(3) || n_wr != 3 * PIX) begin
            n_err++;
            $display("FAIL bp_done: done=%b frames=%0d writes=%0d, want 1/3/%0d", done, frames_done, n_wr, 3 * PIX);
        end
        tick();
    endtask

    task automatic test_addr_error();
        int b;
        clear_counts();
        inj_frame = 2;
        do_start(1'b0, 3, 0);
        b = 0;
        while (busy && b < 3000) begin tick(); b++; end
        inj_frame = 0;
        n_cmp++;
        if (err_seq !== 1'b1 || err_timeout !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ae_flags: es=%b et=%b busy=%b, want 1/0/0", err_seq, err_timeout, busy);
        end
        n_cmp++;
        if (n_rst != 2 || n_done != 0 || frames_done !== FCNT_W'(1)) begin
            n_err++;
            $display("FAIL ae_flush: rst_cycles=%0d done_pulses=%0d frames=%0d, want 2/0/1", n_rst, n_done, frames_done);
        end
    endtask

    task automatic test_lock_timeout();
        int t;
        clear_counts();
        pll_locked = 1'b0;
        do_start(1'b0, 1, 0);
        t = 0;
        while (busy && t < 6000) begin tick(); t++; end
        pll_locked = 1'b1;
        n_cmp++;
        if (err_timeout !== 1'b1 || err_seq !== 1'b0 || t < TIMEOUT || t > TIMEOUT + 4) begin
            n_err++;
            $display("FAIL lock_timeout: et=%b es=%b cycles=%0d, want et=1 es=0 cycles %0d..%0d", err_timeout, err_seq, t, TIMEOUT, TIMEOUT + 4);
        end
        n_cmp++;
        if (n_en != 0 || n_rst != 2 || n_done != 0) begin
            n_err++;
            $display("FAIL lock_flush: en_cycles=%0d rst_cycles=%0d done_pulses=%0d, want 0/2/0", n_en, n_rst, n_done);
        end
    endtask

    task automatic test_stall_timeout();
        int b;
        int t;
        clear_counts();
        do_start(1'b0, 2, 3);
        b = 0;
        while (n_wr < 100 && b < 1000) begin tick(); b++; end
        m_stall = 1'b1;
        t = 0;
        while (busy && t < 6000) begin tick(); t++; end
        m_stall = 1'b0;
        n_cmp++;
        if (err_timeout !== 1'b1 || t < TIMEOUT || t > TIMEOUT + 4) begin
            n_err++;
            $display("FAIL stall_timeout: et=%b cycles=%0d, want et=1 cycles %0d..%0d", err_timeout, t, TIMEOUT, TIMEOUT + 4);
        end
        n_cmp++;
        if (n_rst != 2 || n_done != 0 || frames_done !== '0 || err_seq !== 1'b0) begin
            n_err++;
            $display("FAIL stall_flush: rst_cycles=%0d done_pulses=%0d frames=%0d es=%b, want 2/0/0/0", n_rst, n_done, frames_done, err_seq);
        end
    endtask

    // Abort issued together with the write of pixel 'addr' in frame 'frame'
    task automatic test_abort(input int frame, input int addr, input int exp_frames);
        int b;
        bit fired;
        clear_counts();
        do_start(1'b1, $urandom_range(0, 5), $urandom_range(0, 3));
        fired = 1'b0;
        b = 0;
        while (!(fired && !busy) && b < 8000) begin
            tick();
            b++;
            abort = 1'b0;
            if (!fired && fsm_fifowr && int'(fsm_dout[15:6]) == addr && m_frame == frame) begin
                abort = 1'b1;
                fired = 1'b1;
            end
        end
        abort = 1'b0;
        n_cmp++;
        if (!fired || busy !== 1'b0 || frames_done !== FCNT_W'(exp_frames)) begin
            n_err++;
            $display("FAIL abort_f%0d_a%0d: fired=%b busy=%b frames=%0d, want fired busy=0 frames=%0d", frame, addr, fired, busy, frames_done, exp_frames);
        end
        n_cmp++;
        if (n_rst != 2 || n_done != 0 || err_seq !== 1'b0 || err_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL abort_flush: rst_cycles=%0d done_pulses=%0d es=%b et=%b, want 2/0/0/0", n_rst, n_done, err_seq, err_timeout);
        end
    endtask

    task automatic test_zero_frames();
        clear_counts();
        do_start(1'b0, 0, 1);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL zero_first: busy=%b done=%b, want 1/0", busy, done);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || frames_done !== '0) begin
            n_err++;
            $display("FAIL zero_done: done=%b busy=%b frames=%0d, want 1/0/0", done, busy, frames_done);
        end
        repeat (3) tick();
        n_cmp++;
        if (n_done != 1 || n_en != 0) begin
            n_err++;
            $display("FAIL zero_after: done_pulses=%0d en_cycles=%0d, want 1/0", n_done, n_en);
        end
    endtask

    task automatic test_reset_midrun();
        int b;
        clear_counts();
        do_start(1'b0, 3, 3);
        b = 0;
        while (n_wr < 600 && b < 2000) begin tick(); b++; end
        n_cmp++;
        if (frames_done !== FCNT_W'(1) || fsm_en !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre: frames=%0d en=%b busy=%b, want 1/1/1", frames_done, fsm_en, busy);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({fsm_en, fsm_window_cycles, fsm_rst, busy, done, frames_done, err_timeout, err_seq} !== '0) begin
            n_err++;
            $display("FAIL rst_midrun: got en=%b win=%0d rst=%b busy=%b done=%b frames=%0d, want all 0",
                     fsm_en, fsm_window_cycles, fsm_rst, busy, done, frames_done);
        end
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0 || fsm_en !== 1'b0) begin
            n_err++;
            $display("FAIL rst_after: busy=%b en=%b, want 0/0", busy, fsm_en);
        end
    endtask

    initial begin
        test_reset();
        test_frame_count(2, 1);
        for (int i = 0; i < 3; i++) begin
            test_frame_count($urandom_range(1, 3), $urandom_range(0, 3));
        end
        test_backpressure();
        test_addr_error();
        test_lock_timeout();
        test_stall_timeout();
        test_abort(4, 200, 3);
        test_abort(4, PIX - 1, 4);
        test_zero_frames();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
